frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have port CLOCK_50, input, 1, 50 MHz master clock; all logic on its rising edge.
REQ-002 SHALL have port RESET, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port VSYNC_N, input, 1, VGA vertical sync, active-low, synchronous to CLOCK_50.
REQ-004 SHALL have ports ENV_DONE, ENV_WE (inputs, 1), ENV_X, ENV_Y (inputs, 9) and ENV_PIXEL (input, 8), the environment engine status and write port.
REQ-005 SHALL have ports SPR_DONE, SPR_WE (inputs, 1), SPR_X, SPR_Y (inputs, 9) and SPR_PIXEL (input, 8), the sprite engine status and write port.
REQ-006 SHALL have ports RUN_ENV and RUN_SPR, outputs, 1, the engine run commands.
REQ-007 SHALL have ports FB_WE (output, 1), FB_X, FB_Y (outputs, 9) and FB_PIXEL (output, 8), the arbitrated frame-buffer write port.
REQ-008 SHALL have port PAGE_SEL, output, 1, the page being drawn; the display page is ~PAGE_SEL.
REQ-009 SHALL have ports FRAME_CNT (output, 8, completed page flips, wraps 255->0), OVERRUN (output, 1, sticky), TIMEOUT (output, 1, sticky) and BUSY (output, 1, high in any draw state).

Function
REQ-010 SHALL implement an FSM with states IDLE, ENV_DRAW, ENV_FLUSH, SPR_DRAW, SPR_FLUSH and READY.
REQ-011 SHALL detect a frame edge as VSYNC_N registered 1 and current 0: one-cycle internal pulse VS_EDGE, 1-cycle detection latency.
REQ-012 SHALL, in IDLE, go to ENV_DRAW on VS_EDGE; no page flip on this first edge.
REQ-013 SHALL, in ENV_DRAW, drive RUN_ENV=1 and go to ENV_FLUSH on the cycle ENV_DONE=1.
REQ-014 SHALL, in ENV_FLUSH, hold RUN_ENV=1 for exactly 1 cycle so the engine's 1-cycle-delayed final pixel is written, then go to SPR_DRAW.
REQ-015 SHALL, in SPR_DRAW, drive RUN_SPR=1 and go to SPR_FLUSH on SPR_DONE=1; SPR_FLUSH SHALL hold RUN_SPR=1 for 1 cycle, then go to READY.
REQ-016 SHALL, in READY, drive RUN_ENV=RUN_SPR=0 and, on VS_EDGE, toggle PAGE_SEL, increment FRAME_CNT and go to ENV_DRAW, all in the same cycle.
REQ-017 SHALL set OVERRUN when VS_EDGE occurs in any draw state; the FSM SHALL NOT flip and SHALL continue, flipping at the first VS_EDGE seen in READY.
REQ-018 SHALL set OVERRUN and also take the flip when VS_EDGE coincides with entry to READY (the SPR_FLUSH->READY cycle): the edge counts as missed.
REQ-019 SHALL never assert RUN_ENV and RUN_SPR in the same cycle.
REQ-020 SHALL route write ports combinationally, 0 latency: in ENV_DRAW/ENV_FLUSH FB_* = ENV_*; in SPR_DRAW/SPR_FLUSH FB_* = SPR_*; otherwise FB_WE=0 and FB_X, FB_Y, FB_PIXEL = 0.
REQ-021 SHALL ignore ENV_DONE outside ENV_DRAW and SPR_DONE outside SPR_DRAW.
REQ-022 SHALL run a 17-bit phase counter, cleared on entry to ENV_DRAW and SPR_DRAW and incremented each cycle in those states.
REQ-023 SHALL, when the phase counter reaches 100000 without DONE, set TIMEOUT, drop the run line and go to READY, skipping the remaining phase(s).
REQ-024 SHALL give DONE priority over timeout when both occur in the same cycle.
REQ-025 SHALL keep PAGE_SEL constant between flips; it changes only in READY on VS_EDGE.

Reset
REQ-026 SHALL, while RESET=1, force state IDLE, RUN_ENV=RUN_SPR=0, FB_WE=0, FB_X=FB_Y=0, FB_PIXEL=0, PAGE_SEL=0, FRAME_CNT=0, OVERRUN=TIMEOUT=0, BUSY=0, phase counter 0, VSYNC_N history register 1.
REQ-027 SHALL abort any in-progress draw on RESET mid-frame with no flip; the first VS_EDGE after release starts ENV_DRAW from IDLE.
REQ-028 SHALL clear the OVERRUN and TIMEOUT sticky flags only on RESET.

Verification
REQ-029 Reset release, VSYNC_N 1->0 -> RUN_ENV rises 1 cycle after the falling edge; PAGE_SEL=0, FRAME_CNT=0.
REQ-030 ENV_DONE pulse at cycle N -> RUN_ENV high through N+1, RUN_SPR high from N+2; ENV_WE=1 with ENV_X=319, ENV_Y=239 at N+1 appears on FB_*.
REQ-031 SPR_DONE, then VS_EDGE in READY -> PAGE_SEL 0->1, FRAME_CNT 0->1, RUN_ENV=1 the next cycle; OVERRUN stays 0.
REQ-032 VS_EDGE during SPR_DRAW -> OVERRUN=1 and no flip; flip occurs at the next VS_EDGE after SPR_DONE.
REQ-033 ENV_DONE held 0 -> TIMEOUT=1 after 100000 cycles in ENV_DRAW, RUN_SPR never asserted, state READY.
REQ-034 RESET=1 for 1 cycle mid-ENV_DRAW -> all outputs at their reset values the next cycle; SPR_WE=1 during ENV_DRAW never reaches FB_WE.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered frame FSM running the environment then sprite engines each frame,
// arbitrating their frame-buffer writes and flipping the draw page on vertical sync.
module frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       VSYNC_N,
    input  logic       ENV_DONE,
    input  logic       ENV_WE,
    input  logic [8:0] ENV_X,
    input  logic [8:0] ENV_Y,
    input  logic [7:0] ENV_PIXEL,
    input  logic       SPR_DONE,
    input  logic       SPR_WE,
    input  logic [8:0] SPR_X,
    input  logic [8:0] SPR_Y,
    input  logic [7:0] SPR_PIXEL,
    output logic       RUN_ENV,
    output logic       RUN_SPR,
    output logic       FB_WE,
    output logic [8:0] FB_X,
    output logic [8:0] FB_Y,
    output logic [7:0] FB_PIXEL,
    output logic       PAGE_SEL,
    output logic [7:0] FRAME_CNT,
    output logic       OVERRUN,
    output logic       TIMEOUT,
    output logic       BUSY
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ENV_DRAW  = 3'd1;
    localparam logic [2:0] ENV_FLUSH = 3'd2;
    localparam logic [2:0] SPR_DRAW  = 3'd3;
    localparam logic [2:0] SPR_FLUSH = 3'd4;
    localparam logic [2:0] READY     = 3'd5;

    logic [2:0]  state;
    logic        vs_q;
    logic [16:0] phase;
    logic        vs_edge, env_ph, spr_ph, drawing, tmo;

    // Run lines and write routing are gated by RESET so they read idle during the reset cycle itself
    always_comb begin
        vs_edge   = vs_q & ~VSYNC_N;
        env_ph    = !RESET && (state == ENV_DRAW || state == ENV_FLUSH);
        spr_ph    = !RESET && (state == SPR_DRAW || state == SPR_FLUSH);
        drawing   = state == ENV_DRAW || state == ENV_FLUSH || state == SPR_DRAW || state == SPR_FLUSH;
        tmo       = phase == 17'(TIMEOUT_CYCLES);
        RUN_ENV   = env_ph;
        RUN_SPR   = spr_ph;
        BUSY      = env_ph | spr_ph;
        FB_WE     = env_ph ? ENV_WE    : spr_ph ? SPR_WE    : 1'b0;
        FB_X      = env_ph ? ENV_X     : spr_ph ? SPR_X     : 9'd0;
        FB_Y      = env_ph ? ENV_Y     : spr_ph ? SPR_Y     : 9'd0;
        FB_PIXEL  = env_ph ? ENV_PIXEL : spr_ph ? SPR_PIXEL : 8'd0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= IDLE;
            vs_q      <= 1'b1;
            phase     <= 17'd0;
            PAGE_SEL  <= 1'b0;
            FRAME_CNT <= 8'd0;
            OVERRUN   <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            vs_q <= VSYNC_N;
            if (state == ENV_DRAW || state == SPR_DRAW)
                phase <= phase + 17'd1;
            if (vs_edge && drawing)
                OVERRUN <= 1'b1;
            case (state)
                IDLE: if (vs_edge) begin
                    state <= ENV_DRAW;
                    phase <= 17'd0;
                end
                ENV_DRAW: if (ENV_DONE) state <= ENV_FLUSH;
                else if (tmo) begin
                    state   <= READY;
                    TIMEOUT <= 1'b1;
                end
                ENV_FLUSH: begin
                    state <= SPR_DRAW;
                    phase <= 17'd0;
                end
                SPR_DRAW: if (SPR_DONE) state <= SPR_FLUSH;
                else if (tmo) begin
                    state   <= READY;
                    TIMEOUT <= 1'b1;
                end
                // An edge landing on the way into READY is flagged as missed but still flips
                SPR_FLUSH, READY: if (vs_edge) begin
                    state     <= ENV_DRAW;
                    phase     <= 17'd0;
                    PAGE_SEL  <= ~PAGE_SEL;
                    FRAME_CNT <= FRAME_CNT + 8'd1;
                end else begin
                    state <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
